float_rounder: RTL
==================

# float_rounder

Pipelined rounding and packing stage directly downstream of the exponent/significand extractor in the twos-complement-to-float path. It accepts {sign, exponent, significand, fifth bit} per sample and applies round-half-up using the fifth bit, renormalising on significand carry and saturating on exponent overflow. It emits an 8-bit float {sign, exp[2:0], sig[3:0]} over a valid/ready handshake, and keeps a saturation event counter.

## Interface
- SAT_CNT_W, 8, width of saturation event counter
- clk  input  1  rising-edge clock, sole clock
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  upstream sample valid
- in_ready  output  1  stage can accept a sample this cycle
- sign  input  1  sign of original value (1 = negative)
- exponent  input  3  extractor exponent
- significand  input  4  extractor significand
- fifth  input  1  first bit below significand, rounding bit
- out_valid  output  1  fp_out valid
- out_ready  input  1  downstream accepts fp_out
- fp_out  output  8  {sign, exp[2:0], sig[3:0]}
- sat  output  1  fp_out is a saturated result, qualified by out_valid
- sat_count  output  SAT_CNT_W  saturating count of accepted saturated outputs

## Operation
- Input handshake fires when in_valid && in_ready; output handshake fires when out_valid && out_ready.
- Rounding, computed on the captured sample:
  - fifth = 0: pass exponent and significand unchanged.
  - fifth = 1, significand != 4'b1111: sig = significand + 1, exp unchanged.
  - fifth = 1, significand = 4'b1111, exponent < 7: sig = 4'b1000, exp = exponent + 1.
  - fifth = 1, significand = 4'b1111, exponent = 7: saturate; exp = 7, sig = 4'b1111, sat = 1.
- Sign passes through untouched; sign never affects rounding, because the upstream value is sign-magnitude.
- exponent = 0 follows the same rules as every other exponent; there is no special denormal handling.
- sat_count increments by 1 on each output handshake with sat = 1. It holds at 2^SAT_CNT_W-1 and does not wrap.

## Timing
- Two register stages:
  - S1 captures the raw inputs.
  - S2 holds the rounded, packed result that drives fp_out and sat.
- Each stage has its own valid bit: s1_v and s2_v.
- Stage advance rules:
  - S2 loads from S1 when s1_v && (!s2_v || out_ready).
  - S1 loads from the inputs when in_ready.
  - in_ready = !s1_v || !s2_v || out_ready.
- Latency: 2 cycles from input handshake to out_valid when out_ready = 1. Throughput is 1 sample per cycle.
- Backpressure:
  - With out_ready = 0, the stage absorbs at most 2 samples, then deasserts in_ready.
  - fp_out and sat stay stable while out_valid && !out_ready.
- A simultaneous input and output handshake in the same cycle loses no data and never duplicates a sample.
- Reset values: s1_v = 0, s2_v = 0, out_valid = 0, fp_out = 8'h00, sat = 0, sat_count = 0. in_ready reads 1 during and after reset.
- Reset asserted mid-operation discards all in-flight samples immediately (asynchronous). No output handshake completes for those samples.
- Inputs other than in_valid are don't-care when in_valid = 0.

## Structure
- Shared package float_pkg holds:
  - widths EXP_W = 3 and SIG_W = 4, and FP_W = 8;
  - SIG_MAX = 4'b1111, SIG_RENORM = 4'b1000, EXP_MAX = 3'd7;
  - a packed struct fp8_t {sign, exp, sig}, also used by the upstream extractor and sign-magnitude stages.
- One combinational sub-module, fp_round, maps (exponent, significand, fifth) to (exp, sig, sat). The pipeline registers, handshake logic and counter stay in float_rounder.

## Test plan
- Value 44: sign 0, exp 2, sig 4'b1011, fifth 0, out_ready 1 -> fp_out 8'h2B, sat 0, out_valid exactly 2 cycles after the handshake.
- Round-up and sign: value 46 (exp 2, sig 4'b1011, fifth 1) -> fp_out 8'h2C. The same input with sign 1 -> 8'hAC.
- Renormalise: exp 3, sig 4'b1111, fifth 1 -> fp_out 8'h48, sat 0.
- Saturation:
  - exp 7, sig 4'b1111, fifth 1 -> fp_out 8'h7F, sat 1, sat_count 0 -> 1 on handshake.
  - 300 such samples -> sat_count holds at 255.
- Backpressure:
  - Hold out_ready 0 and offer 3 consecutive samples A, B, C -> A and B accepted, in_ready 0 while C is held, fp_out stable at A.
  - Release out_ready -> A, B, C delivered in order with no gaps or duplicates.
- Reset mid-flight: 2 samples in flight, pulse rst_n low for less than 1 cycle asynchronously -> out_valid 0, fp_out 8'h00, sat_count 0 immediately; the next sample appears 2 cycles after its handshake.

Source files
------------

// File: rtl/float_pkg.sv
// Shared float widths, constants and the packed 8-bit float type for the
// twos-complement-to-float datapath.
package float_pkg;

    localparam int unsigned EXP_W = 3;
    localparam int unsigned SIG_W = 4;
    localparam int unsigned FP_W  = 8;

    localparam logic [SIG_W-1:0] SIG_MAX    = 4'b1111;
    localparam logic [SIG_W-1:0] SIG_RENORM = 4'b1000;
    localparam logic [EXP_W-1:0] EXP_MAX    = 3'd7;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } fp8_t;

    // Unrounded extractor sample as captured by the first pipeline stage.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             fifth;
    } raw_sample_t;

    function automatic fp8_t fp8_pack(input logic             sign,
                                      input logic [EXP_W-1:0] exp,
                                      input logic [SIG_W-1:0] sig);
        fp8_t f;
        f.sign = sign;
        f.exp  = exp;
        f.sig  = sig;
        return f;
    endfunction

endpackage

// File: rtl/fp_round.sv
// Round-half-up on the fifth bit, with renormalisation on significand carry
// and saturation when the exponent cannot grow.
module fp_round
    import float_pkg::*;
(
    input  logic [EXP_W-1:0] exponent_i,
    input  logic [SIG_W-1:0] significand_i,
    input  logic             fifth_i,
    output logic [EXP_W-1:0] exp_o,
    output logic [SIG_W-1:0] sig_o,
    output logic             sat_o
);

    always_comb begin
        exp_o = exponent_i;
        sig_o = significand_i;
        sat_o = 1'b0;
        if (fifth_i) begin
            if (significand_i != SIG_MAX) begin
                sig_o = significand_i + 1'b1;
            end else if (exponent_i != EXP_MAX) begin
                // 1111 + 1 overflows to 1.0000; shift right and bump exponent.
                sig_o = SIG_RENORM;
                exp_o = exponent_i + 1'b1;
            end else begin
                sig_o = SIG_MAX;
                exp_o = EXP_MAX;
                sat_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_rounder.sv
// Two-stage valid/ready pipeline: S1 captures raw samples, S2 holds the
// rounded packed float. Also counts delivered saturated results.
module float_rounder
    import float_pkg::*;
#(
    parameter int unsigned SAT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 sign,
    input  logic [EXP_W-1:0]     exponent,
    input  logic [SIG_W-1:0]     significand,
    input  logic                 fifth,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FP_W-1:0]      fp_out,
    output logic                 sat,
    output logic [SAT_CNT_W-1:0] sat_count
);

    logic                 s1_v_q, s1_v_d;
    raw_sample_t          s1_q, s1_d;
    logic                 s2_v_q, s2_v_d;
    fp8_t                 s2_q, s2_d;
    logic                 sat_q, sat_d;
    logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    logic [EXP_W-1:0] rnd_exp;
    logic [SIG_W-1:0] rnd_sig;
    logic             rnd_sat;
    logic             s2_load;
    logic             out_fire;

    fp_round u_fp_round (
        .exponent_i    (s1_q.exp),
        .significand_i (s1_q.sig),
        .fifth_i       (s1_q.fifth),
        .exp_o         (rnd_exp),
        .sig_o         (rnd_sig),
        .sat_o         (rnd_sat)
    );

    // S2 can take a new result if empty or draining this cycle; S1 then frees up.
    assign in_ready = !s1_v_q || !s2_v_q || out_ready;
    assign s2_load  = s1_v_q && (!s2_v_q || out_ready);
    assign out_fire = s2_v_q && out_ready;

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_d      = s1_q;
        s2_v_d    = s2_v_q;
        s2_d      = s2_q;
        sat_d     = sat_q;
        sat_cnt_d = sat_cnt_q;

        if (in_ready) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_d.sign  = sign;
                s1_d.exp   = exponent;
                s1_d.sig   = significand;
                s1_d.fifth = fifth;
            end
        end

        if (!s2_v_q || out_ready) begin
            s2_v_d = s1_v_q;
        end
        if (s2_load) begin
            s2_d  = fp8_pack(s1_q.sign, rnd_exp, rnd_sig);
            sat_d = rnd_sat;
        end

        if (out_fire && sat_q && (sat_cnt_q != {SAT_CNT_W{1'b1}})) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_q      <= '0;
            s2_v_q    <= 1'b0;
            s2_q      <= '0;
            sat_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_q      <= s1_d;
            s2_v_q    <= s2_v_d;
            s2_q      <= s2_d;
            sat_q     <= sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign out_valid = s2_v_q;
    assign fp_out    = s2_q;
    assign sat       = sat_q;
    assign sat_count = sat_cnt_q;

endmodule
